fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter for the shared synchronous FIFO (16-bit wide, 8 deep).
- Accepts words from NUM_REQ independent requesters over a valid/ready handshake and serialises them onto the FIFO's single write port.
- Confirms each write against the FIFO's registered wr_ack/overflow response and retries any word the FIFO rejected.
- Sits between producer blocks and the FIFO's DUT-side write inputs.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CHECK   = 2'd2,
        BACKOFF = 2'd3
    } arb_state_e;

    localparam int DEFAULT_FIFO_WIDTH = 16;
    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_CNT_W      = 16;

    function automatic int rr_idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first asserted request at or after
// the pointer wins, wrapping modulo NUM_REQ.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = rr_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        any_grant_o = 1'b0;
        grant_idx_o = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!any_grant_o && req_i[idx]) begin
                any_grant_o = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one FIFO write port,
// confirming each write against wr_ack/overflow and retrying rejected words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int  NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int  CNT_W      = DEFAULT_CNT_W,
    localparam int IDX_W      = rr_idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          wr_en_o,
    output logic [FIFO_WIDTH-1:0]         data_in_o,
    input  logic                          full_i,
    input  logic                          wr_ack_i,
    input  logic                          overflow_i,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_id_o,
    output logic [CNT_W-1:0]              ovf_cnt_o
);

    arb_state_e              state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        ovf_cnt_q, ovf_cnt_d;

    logic [FIFO_WIDTH-1:0]   req_words [NUM_REQ];
    logic [IDX_W-1:0]        ptr_after_ack;
    logic [IDX_W-1:0]        arb_ptr;
    logic [IDX_W-1:0]        win_idx;
    logic [NUM_REQ-1:0]      served_mask;
    logic [NUM_REQ-1:0]      arb_req;
    logic                    any_win;
    logic                    ack_ok;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = req_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // In CHECK the just-served requester still shows valid for this cycle, so
    // it is masked out and the search starts from the post-ack pointer.
    assign ptr_after_ack = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
    assign served_mask   = (state_q == CHECK) ? (NUM_REQ'(1) << grant_q) : '0;
    assign arb_req       = req_valid_i & ~served_mask;
    assign arb_ptr       = (state_q == CHECK) ? ptr_after_ack : ptr_q;
    assign ack_ok        = (state_q == CHECK) && wr_ack_i && !overflow_i;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req_i      (arb_req),
        .ptr_i      (arb_ptr),
        .any_grant_o(any_win),
        .grant_idx_o(win_idx)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        ovf_cnt_d = ovf_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_win && !full_i) begin
                    state_d = ISSUE;
                    wr_en_d = 1'b1;
                    data_d  = req_words[win_idx];
                    grant_d = win_idx;
                end
            end
            ISSUE: state_d = CHECK;
            CHECK: begin
                // A simultaneous ack+overflow is treated as a rejection.
                if (overflow_i) begin
                    state_d = BACKOFF;
                    if (ovf_cnt_q != '1) begin
                        ovf_cnt_d = ovf_cnt_q + 1'b1;
                    end
                end else if (wr_ack_i) begin
                    ptr_d = ptr_after_ack;
                    if (any_win && !full_i) begin
                        state_d = ISSUE;
                        wr_en_d = 1'b1;
                        data_d  = req_words[win_idx];
                        grant_d = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = BACKOFF;
                end
            end
            BACKOFF: begin
                if (!full_i) begin
                    state_d = ISSUE;
                    wr_en_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (ack_ok && req_valid_i[grant_q]) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign data_in_o  = data_q;
    assign grant_id_o = grant_q;
    assign ovf_cnt_o  = ovf_cnt_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a hand-computed vector table with the
// FIFO response driven directly, then sequences against a small FIFO model.
module tb_fifo_wr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = 16;

    typedef struct {
        logic [3:0]  valid;
        logic        full;
        logic        ack;
        logic        ovf;
        logic        wr;
        logic [15:0] data;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [W-1:0]   req_word [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           wr_en;
    logic [W-1:0]   data_in;
    logic           full, wr_ack, overflow;
    logic           busy;
    logic [1:0]     grant_id;
    logic [CW-1:0]  ovf_cnt;

    logic           use_model;
    logic           t_full, t_ack, t_ovf;
    logic           m_full, m_ack, m_ovf;
    logic [W-1:0]   mem [8];
    logic [2:0]     m_wp, m_rp;
    logic [3:0]     m_cnt;
    logic           tb_wr, tb_rd;
    logic [W-1:0]   tb_wr_data;
    logic           m_do_rd, m_dut_wr, m_push;
    logic [W-1:0]   m_push_data;
    int             wr_pulses;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs [27];

    assign req_data = {req_word[3], req_word[2], req_word[1], req_word[0]};
    assign full     = use_model ? m_full : t_full;
    assign wr_ack   = use_model ? m_ack  : t_ack;
    assign overflow = use_model ? m_ovf  : t_ovf;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .wr_en_o    (wr_en),
        .data_in_o  (data_in),
        .full_i     (full),
        .wr_ack_i   (wr_ack),
        .overflow_i (overflow),
        .busy_o     (busy),
        .grant_id_o (grant_id),
        .ovf_cnt_o  (ovf_cnt)
    );

    always #5 clk = ~clk;

    // 8-deep FIFO model with registered ack/overflow, sharing the arbiter reset.
    assign m_full      = (m_cnt == 4'd8);
    assign m_do_rd     = tb_rd && (m_cnt != 4'd0);
    assign m_dut_wr    = use_model && wr_en;
    assign m_push      = tb_wr || (m_dut_wr && !m_full);
    assign m_push_data = tb_wr ? tb_wr_data : data_in;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wp      <= '0;
            m_rp      <= '0;
            m_cnt     <= '0;
            m_ack     <= 1'b0;
            m_ovf     <= 1'b0;
            wr_pulses <= 0;
        end else begin
            m_ack <= m_dut_wr && !m_full;
            m_ovf <= m_dut_wr && m_full;
            if (m_dut_wr) wr_pulses <= wr_pulses + 1;
            if (m_push) begin
                mem[m_wp] <= m_push_data;
                m_wp      <= m_wp + 3'd1;
            end
            if (m_do_rd) m_rp <= m_rp + 3'd1;
            m_cnt <= m_cnt + {3'b0, m_push} - {3'b0, m_do_rd};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] v, input logic f, input logic a,
                                input logic o, input logic we, input logic [15:0] d,
                                input logic [1:0] g, input logic [3:0] r,
                                input logic b, input logic [15:0] c);
        vec_t x;
        x.valid = v; x.full = f; x.ack = a; x.ovf = o; x.wr = we;
        x.data = d; x.gid = g; x.rdy = r; x.busy = b; x.cnt = c;
        return x;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = v.valid;
        t_full    = v.full;
        t_ack     = v.ack;
        t_ovf     = v.ovf;
    endtask

    task automatic checkOutput(input vec_t v, input int i);
        checkValue($sformatf("v%0d.wr_en", i),     32'(wr_en),     32'(v.wr));
        checkValue($sformatf("v%0d.data_in", i),   32'(data_in),   32'(v.data));
        checkValue($sformatf("v%0d.grant_id", i),  32'(grant_id),  32'(v.gid));
        checkValue($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(v.rdy));
        checkValue($sformatf("v%0d.busy", i),      32'(busy),      32'(v.busy));
        checkValue($sformatf("v%0d.ovf_cnt", i),   32'(ovf_cnt),   32'(v.cnt));
    endtask

    task automatic checkReset(input string tag);
        checkValue({tag, ".wr_en"},     32'(wr_en),     32'd0);
        checkValue({tag, ".data_in"},   32'(data_in),   32'd0);
        checkValue({tag, ".grant_id"},  32'(grant_id),  32'd0);
        checkValue({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        checkValue({tag, ".busy"},      32'(busy),      32'd0);
        checkValue({tag, ".ovf_cnt"},   32'(ovf_cnt),   32'd0);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        checkReset(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic popCheck(input string name, input logic [15:0] exp);
        @(negedge clk);
        checkValue(name, 32'(mem[m_rp]), 32'(exp));
        tb_rd = 1'b1;
        @(posedge clk);
        #1 tb_rd = 1'b0;
    endtask

    int         n;
    int         order [5];
    int         at [5];
    int         idx;
    logic [3:0] rdy;
    logic       first0;
    logic       saw_wr;
    logic       saw_busy;
    logic       seen;

    initial begin
        rst_n = 1'b0; use_model = 1'b0; req_valid = '0;
        t_full = 1'b0; t_ack = 1'b0; t_ovf = 1'b0;
        tb_wr = 1'b0; tb_rd = 1'b0; tb_wr_data = '0;
        req_word[0] = 16'h1111; req_word[1] = 16'h0BAD;
        req_word[2] = 16'hA5A5; req_word[3] = 16'h4444;

        //          valid   f  a  o | wr data    g  rdy     busy cnt
        vecs[0]  = mk(4'b0000, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 0, 0);
        vecs[1]  = mk(4'b0100, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 0, 0);
        vecs[2]  = mk(4'b0100, 0, 0, 0, 1, 16'hA5A5, 2, 4'b0000, 1, 0);
        vecs[3]  = mk(4'b0100, 0, 1, 0, 0, 16'hA5A5, 2, 4'b0100, 1, 0);
        vecs[4]  = mk(4'b0000, 0, 0, 0, 0, 16'hA5A5, 2, 4'b0000, 0, 0);
        vecs[5]  = mk(4'b0010, 0, 0, 0, 0, 16'hA5A5, 2, 4'b0000, 0, 0);
        vecs[6]  = mk(4'b0010, 0, 0, 0, 1, 16'h0BAD, 1, 4'b0000, 1, 0);
        vecs[7]  = mk(4'b0010, 0, 0, 1, 0, 16'h0BAD, 1, 4'b0000, 1, 0);
        vecs[8]  = mk(4'b0010, 1, 0, 0, 0, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[9]  = mk(4'b0011, 0, 0, 0, 0, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[10] = mk(4'b0011, 0, 0, 0, 1, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[11] = mk(4'b0011, 0, 0, 0, 0, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[12] = mk(4'b0011, 0, 0, 0, 0, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[13] = mk(4'b0011, 0, 0, 0, 1, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[14] = mk(4'b0011, 0, 1, 1, 0, 16'h0BAD, 1, 4'b0000, 1, 1);
        vecs[15] = mk(4'b0011, 0, 0, 0, 0, 16'h0BAD, 1, 4'b0000, 1, 2);
        vecs[16] = mk(4'b0011, 0, 0, 0, 1, 16'h0BAD, 1, 4'b0000, 1, 2);
        vecs[17] = mk(4'b0011, 0, 1, 0, 0, 16'h0BAD, 1, 4'b0010, 1, 2);
        vecs[18] = mk(4'b0001, 0, 0, 0, 1, 16'h1111, 0, 4'b0000, 1, 2);
        vecs[19] = mk(4'b0000, 0, 1, 0, 0, 16'h1111, 0, 4'b0000, 1, 2);
        vecs[20] = mk(4'b0000, 0, 0, 0, 0, 16'h1111, 0, 4'b0000, 0, 2);
        vecs[21] = mk(4'b1000, 1, 0, 0, 0, 16'h1111, 0, 4'b0000, 0, 2);
        vecs[22] = mk(4'b1000, 1, 0, 0, 0, 16'h1111, 0, 4'b0000, 0, 2);
        vecs[23] = mk(4'b1000, 0, 0, 0, 0, 16'h1111, 0, 4'b0000, 0, 2);
        vecs[24] = mk(4'b1000, 0, 0, 0, 1, 16'h4444, 3, 4'b0000, 1, 2);
        vecs[25] = mk(4'b1000, 1, 1, 0, 0, 16'h4444, 3, 4'b1000, 1, 2);
        vecs[26] = mk(4'b0000, 0, 0, 0, 0, 16'h4444, 3, 4'b0000, 0, 2);

        repeat (2) @(posedge clk);
        #1 checkReset("reset0");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1 checkOutput(vecs[i], i);
        end

        // All four requesters with the model FIFO; requester 0 has a second word.
        use_model = 1'b1;
        t_full = 1'b0; t_ack = 1'b0; t_ovf = 1'b0;
        doReset("reset1");
        req_word[0] = 16'd1; req_word[1] = 16'd2; req_word[2] = 16'd3; req_word[3] = 16'd4;
        req_valid = 4'b1111;
        first0 = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            rdy = req_ready;
            if (rdy != 4'b0000) begin
                idx = 0;
                for (int b = 0; b < N; b++) if (rdy[b]) idx = b;
                order[n] = idx;
                at[n] = cyc;
                n++;
            end
            @(posedge clk);
            #1;
            for (int b = 0; b < N; b++) begin
                if (rdy[b]) begin
                    if (b == 0 && first0) begin
                        req_word[0] = 16'd5;
                        first0 = 1'b0;
                    end else begin
                        req_valid[b] = 1'b0;
                    end
                end
            end
        end
        checkValue("rr.ready_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < n) begin
                checkValue($sformatf("rr.order%0d", k), 32'(order[k]), 32'(k % 4));
                if (k > 0) checkValue($sformatf("rr.gap%0d", k), 32'(at[k] - at[k-1]), 32'd2);
            end
        end
        repeat (3) @(negedge clk);
        checkValue("rr.fifo_count", 32'(m_cnt), 32'd5);
        for (int k = 0; k < 5; k++) popCheck($sformatf("rr.fifo%0d", k), 16'(k + 1));

        // Full FIFO: no write issued until one word is read out.
        doReset("reset2");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tb_wr = 1'b1;
            tb_wr_data = 16'h0100 + 16'(k);
        end
        @(negedge clk);
        tb_wr = 1'b0;
        req_word[1] = 16'h0999;
        req_valid = 4'b0010;
        saw_wr = 1'b0;
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wr_en) saw_wr = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        checkValue("full.no_wr_en", 32'(saw_wr), 32'd0);
        checkValue("full.not_busy", 32'(saw_busy), 32'd0);
        popCheck("full.pop0", 16'h0100);
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (req_ready[1]) seen = 1'b1;
        end
        checkValue("full.ready1", 32'(seen), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(negedge clk);
        checkValue("full.wr_pulses", 32'(wr_pulses), 32'd1);
        checkValue("full.fifo_count", 32'(m_cnt), 32'd8);
        for (int k = 1; k < 8; k++) popCheck($sformatf("full.pop%0d", k), 16'h0100 + 16'(k));
        popCheck("full.word9", 16'h0999);

        // Reset asserted while the arbiter sits in CHECK.
        doReset("reset3");
        req_word[3] = 16'h3333;
        req_valid = 4'b1000;
        repeat (2) @(negedge clk);
        checkValue("rst.in_check_busy", 32'(busy), 32'd1);
        checkValue("rst.in_check_wr_en", 32'(wr_en), 32'd0);
        rst_n = 1'b0;
        #1 checkReset("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (req_ready[3]) seen = 1'b1;
        end
        checkValue("rst.ready3", 32'(seen), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        checkValue("rst.wr_pulses", 32'(wr_pulses), 32'd1);
        checkValue("rst.fifo_count", 32'(m_cnt), 32'd1);
        checkValue("rst.fifo_word", 32'(mem[m_rp]), 32'h3333);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
